// File: rtl/rv_dmem_responder.sv
// Slow data-memory responder for the core load/store port.
// One request at a time: accept, wait LATENCY cycles, access a 64-bit-wide array, respond.
// Optional feature macro: RV_DMEM_ALIGN_CHK_EN. When it is defined, misaligned accesses
// respond with an error. When it is undefined, the address is aligned down to the access size.
module rv_dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned AW      = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [63:0] req_addr_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e         state_q;
    logic [3:0]     cnt_q;
    logic [AW-1:0]  idx_q;
    logic [2:0]     off_q;
    logic           we_q;
    logic [2:0]     funct3_q;
    logic [63:0]    wdata_q;
    logic           req_ready_q;
    logic           rsp_valid_q;
    logic [63:0]    rsp_rdata_q;
    logic           rsp_err_q;

    logic [63:0]    mem_q [DEPTH];

    logic           accept;
    logic           enter_resp;
    logic           in_idle;
    logic [AW-1:0]  cur_idx;
    logic [2:0]     cur_off;
    logic           cur_we;
    logic [2:0]     cur_f3;
    logic [63:0]    cur_wdata;
    logic [2:0]     low_mask;
    logic [7:0]     size_mask;
    logic [2:0]     off_eff;
    logic [5:0]     shamt;
    logic           acc_err;
    logic [63:0]    rd_word;
    logic [63:0]    rd_shift;
    logic [63:0]    ld_ext;
    logic [63:0]    rsp_data;
    logic [7:0]     wr_be;
    logic [63:0]    wr_data;
    logic           do_write;
    logic           unused_addr;

    assign unused_addr = ^req_addr_i[63:AW+3];

    assign accept     = req_valid_i & req_ready_q;
    assign in_idle    = (state_q == StIdle);
    // With zero latency the access happens on the accept edge, before anything is latched.
    assign enter_resp = (in_idle & accept & (LATENCY == 0)) |
                        ((state_q == StWait) & (cnt_q == 4'd0));

    // Select the transaction being accessed: live inputs in IDLE, latched copy otherwise.
    always_comb begin
        cur_idx   = idx_q;
        cur_off   = off_q;
        cur_we    = we_q;
        cur_f3    = funct3_q;
        cur_wdata = wdata_q;
        if (in_idle) begin
            cur_idx   = req_addr_i[AW+2:3];
            cur_off   = req_addr_i[2:0];
            cur_we    = req_we_i;
            cur_f3    = req_funct3_i;
            cur_wdata = req_wdata_i;
        end
    end

    // Decode size, alignment, error and load/store data for the selected transaction.
    always_comb begin
        low_mask  = 3'b000;
        size_mask = 8'h01;
        unique case (cur_f3[1:0])
            2'b00: begin low_mask = 3'b000; size_mask = 8'h01; end
            2'b01: begin low_mask = 3'b001; size_mask = 8'h03; end
            2'b10: begin low_mask = 3'b011; size_mask = 8'h0f; end
            2'b11: begin low_mask = 3'b111; size_mask = 8'hff; end
            default: ;
        endcase
        off_eff = cur_off & ~low_mask;
        shamt   = {off_eff, 3'b000};

        acc_err = cur_we ? cur_f3[2] : (cur_f3 == 3'b111);
`ifdef RV_DMEM_ALIGN_CHK_EN
        if ((cur_off & low_mask) != 3'b000) begin
            acc_err = 1'b1;
        end
`endif

        rd_word  = mem_q[cur_idx];
        rd_shift = rd_word >> shamt;
        ld_ext   = 64'd0;
        case (cur_f3)
            3'b000:  ld_ext = {{56{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  ld_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b011:  ld_ext = rd_shift;
            3'b100:  ld_ext = {56'd0, rd_shift[7:0]};
            3'b101:  ld_ext = {48'd0, rd_shift[15:0]};
            3'b110:  ld_ext = {32'd0, rd_shift[31:0]};
            default: ld_ext = 64'd0;
        endcase
        rsp_data = (cur_we | acc_err) ? 64'd0 : ld_ext;

        wr_be    = size_mask << off_eff;
        wr_data  = cur_wdata << shamt;
        do_write = rstn & enter_resp & cur_we & ~acc_err;
    end

    // Byte-masked store into the array on the edge entering RESP; contents are never reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) begin
                    mem_q[cur_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            off_q       <= 3'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            wdata_q     <= 64'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        idx_q       <= req_addr_i[AW+2:3];
                        off_q       <= req_addr_i[2:0];
                        we_q        <= req_we_i;
                        funct3_q    <= req_funct3_i;
                        wdata_q     <= req_wdata_i;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_data;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_data;
                        rsp_err_q   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Scoreboard bench for rv_dmem_responder: the driver pushes the expected response of each
// request, and a monitor pops and compares on every response handshake.
module tb_rv_dmem_responder;

    localparam int unsigned Latency = 2;

    logic        clk;
    logic        rstn;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [63:0] req_addr_i;
    logic [2:0]  req_funct3_i;
    logic [63:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;

    int checks   = 0;
    int failures = 0;
    logic [64:0] exp_q [$];

    rv_dmem_responder #(
        .DEPTH   (256),
        .AW      (8),
        .LATENCY (Latency)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_funct3_i (req_funct3_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endfunction

    // Monitor: compare each handshaken response with the oldest expected entry.
    always @(negedge clk) begin
        if (rstn && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_rsp");
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata_o, e[63:0]);
                chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, e[64]});
            end
        end
    end

    task automatic send(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                        input logic [63:0] wdata, input logic [63:0] exp_d,
                        input logic exp_e, input bit push);
        int t;
        if (push) exp_q.push_back({exp_e, exp_d});
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_addr_i   = addr;
        req_funct3_i = f3;
        req_wdata_i  = wdata;
        t = 0;
        while (!req_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready_o) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        // Scramble the inputs: the DUT must use its latched copy.
        req_valid_i  = 1'b0;
        req_we_i     = ~we;
        req_addr_i   = ~addr;
        req_funct3_i = ~f3;
        req_wdata_i  = ~wdata;
    endtask

    // Count edges from the accept edge (inclusive) to the first visible rsp_valid_o.
    task automatic wait_valid(output int edges);
        edges = 1;
        @(negedge clk);
        while (!rsp_valid_o && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!rsp_valid_o) fail_now("rsp_timeout");
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (rsp_valid_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (rsp_valid_o) fail_now("handshake_timeout");
    endtask

    task automatic txn(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                       input logic [63:0] wdata, input logic [63:0] exp_d, input logic exp_e);
        int e;
        send(we, addr, f3, wdata, exp_d, exp_e, 1'b1);
        wait_valid(e);
        wait_done();
    endtask

    initial begin
        int e;
        rstn         = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = 64'd0;
        req_funct3_i = 3'd0;
        req_wdata_i  = 64'd0;
        rsp_ready_i  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", {63'd0, req_ready_o}, 64'd1);
        chk("reset_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        chk("reset_rsp_rdata", rsp_rdata_o, 64'd0);
        chk("reset_rsp_err", {63'd0, rsp_err_o}, 64'd0);

        // Prior contents for the reset-drop test.
        txn(1'b1, 64'h18, 3'b011, 64'h0000_0000_0000_5a5a, 64'd0, 1'b0);

        // SD 0x10 with latency measurement, then LD back.
        send(1'b1, 64'h10, 3'b011, 64'h8877_6655_4433_2211, 64'd0, 1'b0, 1'b1);
        wait_valid(e);
        chk("latency_edges", 64'(e), 64'(Latency + 1));
        wait_done();
        txn(1'b0, 64'h10, 3'b011, 64'd0, 64'h8877_6655_4433_2211, 1'b0);

        // Sub-word loads with sign/zero extension.
        txn(1'b0, 64'h17, 3'b000, 64'd0, 64'hffff_ffff_ffff_ff88, 1'b0);
        txn(1'b0, 64'h17, 3'b100, 64'd0, 64'h0000_0000_0000_0088, 1'b0);
        txn(1'b0, 64'h16, 3'b001, 64'd0, 64'hffff_ffff_ffff_8877, 1'b0);
        txn(1'b0, 64'h14, 3'b110, 64'd0, 64'h0000_0000_8877_6655, 1'b0);
        txn(1'b0, 64'h10, 3'b000, 64'd0, 64'h0000_0000_0000_0011, 1'b0);

        // Byte store keeps neighbours; address wraps modulo DEPTH*8.
        txn(1'b1, 64'h11, 3'b000, 64'h0000_0000_0000_00aa, 64'd0, 1'b0);
        txn(1'b0, 64'h10, 3'b011, 64'd0, 64'h8877_6655_4433_aa11, 1'b0);
        txn(1'b0, 64'h810, 3'b011, 64'd0, 64'h8877_6655_4433_aa11, 1'b0);

        // Backpressure: response held for 5 cycles, next request waits for the handshake.
        rsp_ready_i = 1'b0;
        send(1'b0, 64'h10, 3'b011, 64'd0, 64'h8877_6655_4433_aa11, 1'b0, 1'b1);
        wait_valid(e);
        exp_q.push_back({1'b0, 64'h0000_0000_0000_5a5a});
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_addr_i   = 64'h18;
        req_funct3_i = 3'b011;
        req_wdata_i  = 64'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
            chk("hold_rsp_rdata", rsp_rdata_o, 64'h8877_6655_4433_aa11);
            chk("hold_req_ready", {63'd0, req_ready_o}, 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("handshake_req_ready", {63'd0, req_ready_o}, 64'd0);
        @(negedge clk);
        chk("post_hs_req_ready", {63'd0, req_ready_o}, 64'd1);
        chk("post_hs_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        wait_valid(e);
        wait_done();

        // Alignment behaviour and reserved encodings.
`ifdef RV_DMEM_ALIGN_CHK_EN
        txn(1'b0, 64'h12, 3'b010, 64'd0, 64'd0, 1'b1);
        txn(1'b1, 64'h12, 3'b010, 64'h0000_0000_dead_beef, 64'd0, 1'b1);
        txn(1'b0, 64'h10, 3'b011, 64'd0, 64'h8877_6655_4433_aa11, 1'b0);
`else
        txn(1'b0, 64'h12, 3'b010, 64'd0, 64'h0000_0000_4433_aa11, 1'b0);
`endif
        txn(1'b0, 64'h10, 3'b111, 64'd0, 64'd0, 1'b1);
        txn(1'b1, 64'h10, 3'b100, 64'hffff_ffff_ffff_ffff, 64'd0, 1'b1);
        txn(1'b0, 64'h10, 3'b011, 64'd0, 64'h8877_6655_4433_aa11, 1'b0);

        // Reset during WAIT drops the pending store.
        send(1'b1, 64'h18, 3'b011, 64'h1, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("after_rst_req_ready", {63'd0, req_ready_o}, 64'd1);
        chk("after_rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        txn(1'b0, 64'h18, 3'b011, 64'd0, 64'h0000_0000_0000_5a5a, 1'b0);

        // Half store at offset 2 merges into the existing word.
        txn(1'b1, 64'h1a, 3'b001, 64'h0000_0000_0000_beef, 64'd0, 1'b0);
        txn(1'b0, 64'h18, 3'b011, 64'd0, 64'h0000_0000_beef_5a5a, 1'b0);

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) fail_now("scoreboard_drain");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
